// File: rtl/gpu_pkg.sv
// Shared GPU pixel-path constants and colour types.
package gpu_pkg;

    localparam int LCD_WIDTH   = 160;
    localparam int COLOR_W     = 15;
    localparam int LINE_ADDR_W = 8;

    typedef logic [COLOR_W-1:0] rgb555_t;

    typedef struct packed {
        logic [4:0] r;
        logic [4:0] g;
        logic [4:0] b;
    } rgb555_fields_t;

    // Splits a packed RGB555 word into its colour channels.
    function automatic rgb555_fields_t unpack_rgb555(input rgb555_t c);
        rgb555_fields_t f;
        f.r = c[14:10];
        f.g = c[9:5];
        f.b = c[4:0];
        return f;
    endfunction

endpackage

// File: rtl/line_bank.sv
// One scanline bank: data array, per-entry valid bits, first-writer-wins
// check and a combinational read. The valid vector can be wiped in one edge.
module line_bank
    import gpu_pkg::*;
#(
    parameter int                DATA_W      = COLOR_W,
    parameter int                DEPTH       = LCD_WIDTH,
    parameter int                ADDR_W      = LINE_ADDR_W,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_valid,
    input  logic              wr_en,
    input  logic              wr_first,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_blocked,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]  valid_bits;
    logic              do_write;

    // A first-only write is blocked when the entry already holds this line's pixel.
    always_comb begin
        wr_blocked = wr_first && valid_bits[wr_addr];
        do_write   = wr_en && !wr_blocked;
        rd_data    = valid_bits[rd_addr] ? data_mem[rd_addr] : CLEAR_VALUE;
    end

    // Data storage is never reset; stale contents are hidden by the valid bits.
    always_ff @(posedge clk) begin
        if (do_write) begin
            data_mem[wr_addr] <= wr_data;
        end
    end

    // Valid bits: whole-vector clear on a bank swap, otherwise set by writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_bits <= '0;
        end else if (clr_valid) begin
            valid_bits <= '0;
        end else if (do_write) begin
            valid_bits[wr_addr] <= 1'b1;
        end
    end

endmodule

// File: rtl/scanline_line_buffer.sv
// Ping-pong scanline buffer: the fetcher fills one bank while the LCD
// stage reads the other; a swap pulse exchanges them at the line boundary.
module scanline_line_buffer
    import gpu_pkg::*;
#(
    parameter int                DATA_W      = COLOR_W,
    parameter int                DEPTH       = LCD_WIDTH,
    parameter int                ADDR_W      = LINE_ADDR_W,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              swap,
    input  logic              wr_en,
    input  logic              wr_first,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_drop,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              wr_bank
);

    // One extra bit so DEPTH == 2^ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    logic              wr_in_range;
    logic              rd_in_range;
    logic              rd_bank;
    logic              sel_blocked;
    logic [DATA_W-1:0] sel_rd_data;
    logic              bank_blocked [2];
    logic [DATA_W-1:0] bank_rd_data [2];

    // Range checks and bank steering; the read bank is always the other one.
    always_comb begin
        wr_in_range = {1'b0, wr_addr} < DEPTH_LIM;
        rd_in_range = {1'b0, rd_addr} < DEPTH_LIM;
        rd_bank     = ~wr_bank;
        sel_blocked = bank_blocked[wr_bank];
        sel_rd_data = bank_rd_data[rd_bank];
    end

    // Bank b writes only while it is the write bank, and has its valid bits
    // cleared when a swap is about to make it the write bank.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        line_bank #(
            .DATA_W      (DATA_W),
            .DEPTH       (DEPTH),
            .ADDR_W      (ADDR_W),
            .CLEAR_VALUE (CLEAR_VALUE)
        ) u_bank (
            .clk        (clk),
            .rst        (rst),
            .clr_valid  (swap && (wr_bank != 1'(b))),
            .wr_en      (wr_en && wr_in_range && (wr_bank == 1'(b))),
            .wr_first   (wr_first),
            .wr_addr    (wr_addr),
            .wr_data    (wr_data),
            .wr_blocked (bank_blocked[b]),
            .rd_addr    (rd_addr),
            .rd_data    (bank_rd_data[b])
        );
    end

    // Bank select toggles on every swap.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank <= 1'b0;
        end else if (swap) begin
            wr_bank <= ~wr_bank;
        end
    end

    // Registered read path; rd_data holds its last value when no read is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_in_range ? sel_rd_data : CLEAR_VALUE;
            end
        end
    end

    // Drop flag for writes that were out of range or lost first-writer priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_drop <= 1'b0;
        end else begin
            wr_drop <= wr_en && (!wr_in_range || sel_blocked);
        end
    end

endmodule

// File: doc/scanline_line_buffer.md
# scanline_line_buffer

Parametrised, double-buffered (ping-pong) scanline buffer for the GPU pixel path. The pixel fetcher writes colour entries for line N into one bank while the LCD output stage reads line N−1 from the other. A `swap` pulse at line boundary exchanges the banks. Per-entry valid bits give single-cycle logical clear and an optional first-writer-wins mode for sprite priority. Reads are registered.

## Interface
Parameters:
- `DATA_W`, 15: entry width (RGB555).
- `DEPTH`, 160: entries per line.
- `ADDR_W`, 8: address width; must satisfy 2^ADDR_W ≥ DEPTH.
- `CLEAR_VALUE`, 0: value returned for entries not written this line.

Ports:
- `clk`  in  1: single clock, all logic on posedge.
- `rst`  in  1: synchronous, active-high reset.
- `swap`  in  1: one-cycle pulse that exchanges the write and read banks.
- `wr_en`  in  1: write strobe.
- `wr_first`  in  1: when 1, the write only lands if the entry is not yet valid this line.
- `wr_addr`  in  ADDR_W: write address.
- `wr_data`  in  DATA_W: write data.
- `wr_drop`  out  1: registered pulse; previous-cycle write was discarded (out of range, or blocked by `wr_first`).
- `rd_en`  in  1: read strobe.
- `rd_addr`  in  ADDR_W: read address.
- `rd_data`  out  DATA_W: registered read data.
- `rd_valid`  out  1: `rd_data` is valid this cycle.
- `wr_bank`  out  1: index of the current write bank. The read bank is `~wr_bank`.

## Operation
- Two banks, each holding `DEPTH`×`DATA_W` data plus a `DEPTH`-bit valid vector.
- Write, when `wr_en`=1:
  - If `wr_addr` ≥ `DEPTH`, the write is discarded and `wr_drop`=1 next cycle.
  - If `wr_first`=1 and the target valid bit is already 1, the write is discarded and `wr_drop`=1 next cycle.
  - Otherwise, data is stored in the write bank and its valid bit is set.
- Read, when `rd_en`=1: returns the read-bank entry if its valid bit is 1. Otherwise it returns `CLEAR_VALUE`. It also returns `CLEAR_VALUE` when `rd_addr` ≥ `DEPTH`.
- On `swap`:
  - `wr_bank` toggles.
  - The entire valid vector of the new write bank (the former read bank) clears in that same edge.
  - Data contents are untouched; no clear sweep is needed.
- Repeated `swap` without any writes is legal. A read then returns `CLEAR_VALUE` everywhere.
- Reset:
  - `wr_bank`=0.
  - Both valid vectors are 0.
  - `rd_data`=0, `rd_valid`=0, `wr_drop`=0.
  - Data arrays are not reset.

## Timing
- Read latency is 1 cycle: `rd_en` sampled at edge k gives `rd_data`/`rd_valid` after edge k. `rd_valid` is exactly the registered `rd_en`.
- Write takes effect at the sampling edge. `wr_drop` follows 1 cycle later.
- A write and `swap` in the same cycle:
  - The write lands in the pre-swap write bank, which becomes the read bank.
  - The valid-clear applies only to the other bank.
- A read and `swap` in the same cycle: the read uses the pre-swap read bank.
- A read and write to the same bank/address in the same cycle: impossible, because the read bank and write bank always differ.
- Back-to-back `wr_first` writes to one address on consecutive cycles: the second sees the valid bit set by the first and is dropped.
- `rst` asserted mid-line:
  - Overrides all other inputs that cycle.
  - Any pending `rd_valid` and `wr_drop` are cleared.
- Throughput: one write and one read every cycle.

## Structure
- Shared package `gpu_pkg`: `LCD_WIDTH`=160, `COLOR_W`=15, `LINE_ADDR_W`=8, and an RGB555 colour typedef.
- Sub-module `line_bank`:
  - One bank: data array, valid vector, write port with first-only check, combinational read, and a `clr_valid` input.
  - Instantiated twice.
  - The top level holds the bank select, output registers, range check and `wr_drop`.

## Test plan
- Reset, then `rd_en` at addr 0..159 → `rd_valid` one cycle later, `rd_data`=0 throughout, `wr_bank`=0.
- Write addr 5 = 0x7C1F, `swap`, read addr 5 → 0x7C1F. Read addr 6 → 0x0000. `wr_bank`=1.
- `wr_first`=1: write addr 10 = 0x001F, then addr 10 = 0x03E0. Second write gives `wr_drop`=1. After `swap`, read addr 10 → 0x001F.
- Write addr 160 = 0x1234 → `wr_drop`=1, no entry changed. Read addr 200 → `CLEAR_VALUE`.
- Write addr 3 = 0x0ABC in the same cycle as `swap`, then read addr 3 → 0x0ABC. Two further swaps with no writes, then read addr 3 → 0x0000.
- Fill line, `swap`, assert `rst` during a read burst. Next cycle `rd_valid`=0, `wr_bank`=0, and all reads return 0.
